// File: rtl/image_ram_writer_pkg.sv
//==============================================================================
// Module  : image_mem_pkg
// Brief   : Shared image-memory types, default geometry and writer FSM encoding.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package image_mem_pkg;

    localparam int unsigned c_DATA_W     = 24;
    localparam int unsigned c_ADDR_W     = 17;
    localparam int unsigned c_IMG_WIDTH  = 320;
    localparam int unsigned c_IMG_HEIGHT = 320;

    typedef logic [c_DATA_W-1:0] pixel_t;
    typedef logic [c_ADDR_W-1:0] img_addr_t;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = c_ST_IDLE,
        WRITE = c_ST_WRITE,
        DONE  = c_ST_DONE
    } writer_state_e;

    // Bit width of a 0..n-1 counter, never below one bit.
    function automatic int unsigned field_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/image_ram_writer_if.sv
//==============================================================================
// Module  : image_ram_writer_if
// Brief   : Pixel stream (valid/ready) plus single-port memory write bus.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface image_ram_writer_if
    import image_mem_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned ADDR_W = c_ADDR_W
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // master: pixel source that also observes the memory side
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wr_en, wr_addr, wr_data
    );

endinterface

`default_nettype wire

// File: rtl/image_ram_writer_raster_counter.sv
//==============================================================================
// Module  : raster_counter
// Brief   : Column/row/linear pixel counter with last-pixel flag for one frame.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module raster_counter
    import image_mem_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = c_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = c_IMG_HEIGHT,
    parameter int unsigned CNT_W      = c_ADDR_W,
    parameter int unsigned COL_W      = field_width(IMG_WIDTH),
    parameter int unsigned ROW_W      = field_width(IMG_HEIGHT)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             advance,
    output logic      [COL_W-1:0] col,
    output logic      [ROW_W-1:0] row,
    output logic      [CNT_W-1:0] count,
    output logic                  is_last
);

    localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(IMG_WIDTH * IMG_HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_col   <= '0;
            r_row   <= '0;
            r_count <= '0;
        end else if (advance) begin
            r_count <= r_count + 1'b1;
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_MAX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col     = r_col;
    assign row     = r_row;
    assign count   = r_count;
    assign is_last = (r_count == c_CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/image_ram_writer.sv
//==============================================================================
// Module  : image_ram_writer
// Brief   : Writes one raster-ordered frame from a pixel stream into image RAM.
//           Optional running pixel checksum: IMAGE_RAM_WRITER_CHECKSUM_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module image_ram_writer
    import image_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = c_DATA_W,
    parameter int unsigned ADDR_W     = c_ADDR_W,
    parameter int unsigned IMG_WIDTH  = c_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = c_IMG_HEIGHT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    image_ram_writer_if.slave      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_err
`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);

    localparam int unsigned c_COL_W = field_width(IMG_WIDTH);
    localparam int unsigned c_ROW_W = field_width(IMG_HEIGHT);

    writer_state_e     r_state;
    writer_state_e     w_next_state;

    logic              w_s_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_pix;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_count;
    logic [c_COL_W-1:0] w_unused_col;
    logic [c_ROW_W-1:0] w_unused_row;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_frame_err;

    assign w_start_ok = start && (r_state == IDLE);
    assign w_accept   = bus.s_valid && w_s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = WRITE;
            WRITE:   if (w_accept && (bus.s_last || w_last_pix)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake and status decode straight from the state register.
    always_comb begin
        w_s_ready = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            WRITE: begin
                w_s_ready = 1'b1;
                w_busy    = 1'b1;
            end
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .CNT_W      (ADDR_W),
        .COL_W      (c_COL_W),
        .ROW_W      (c_ROW_W)
    ) u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_start_ok),
        .advance (w_accept),
        .col     (w_unused_col),
        .row     (w_unused_row),
        .count   (w_count),
        .is_last (w_last_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_start_ok) begin
                r_base      <= base_addr;
                r_frame_err <= 1'b0;
            end
            if (w_accept) begin
                // Address sum is truncated to ADDR_W, so it wraps through zero.
                r_wr_addr <= r_base + w_count;
                r_wr_data <= bus.s_data;
                // Early s_last and a missing s_last on the final pixel both flag.
                if (bus.s_last != w_last_pix) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + 32'(bus.s_data);
        end
    end

    assign checksum = r_checksum;
`endif

    assign bus.s_ready = w_s_ready;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign busy        = w_busy;
    assign done        = w_done;
    assign frame_err   = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_image_ram_writer.sv
//==============================================================================
// Module  : tb_image_ram_writer
// Brief   : Directed bench for image_ram_writer on a 4x2 frame, 17-bit address.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_image_ram_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [16:0] base_addr;
    logic        busy;
    logic        done;
    logic        frame_err;
`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_cmp;
    int n_err;

    image_ram_writer_if #(.DATA_W(24), .ADDR_W(17)) bus ();

    image_ram_writer #(
        .DATA_W     (24),
        .ADDR_W     (17),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: n pixels, s_last on last_idx (-1 = never), optional idle gap
    // before every pixel after the first, start poked with a bogus base at poke_idx.
    task automatic frame(input logic [16:0] base, input int n, input int last_idx,
                         input bit gaps, input logic [23:0] d0, input logic [23:0] dstep,
                         input int poke_idx, input bit exp_err);
        logic [16:0] a;
        logic [23:0] d;
        logic [31:0] sum;
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
        base_addr = ~base;
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", bus.s_ready, 1);
        chk("err_cleared_on_start", frame_err, 0);
        sum = '0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                bus.s_valid = 1'b0;
                tick();
                chk("gap_no_write", bus.wr_en, 0);
                chk("gap_ready", bus.s_ready, 1);
            end
            d = d0 + 24'(i) * dstep;
            a = base + 17'(i);
            bus.s_valid = 1'b1;
            bus.s_data  = d;
            bus.s_last  = (i == last_idx);
            if (i == poke_idx) begin
                start     = 1'b1;
                base_addr = 17'h0ABCD;
            end
            tick();
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            start       = 1'b0;
            sum         = sum + {8'h00, d};
            chk("wr_en", bus.wr_en, 1);
            chk("wr_addr", bus.wr_addr, a);
            chk("wr_data", bus.wr_data, d);
            chk("done_with_write", done, (i == n - 1));
            chk("busy_during_frame", busy, !(i == n - 1));
        end
        chk("frame_err_at_done", frame_err, exp_err);
        chk("ready_low_at_done", bus.s_ready, 0);
`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
        chk("checksum_at_done", checksum, sum);
`endif
        // start during DONE must be ignored
        start     = 1'b1;
        base_addr = 17'h05555;
        tick();
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
        chk("idle_no_write", bus.wr_en, 0);
        chk("idle_not_ready", bus.s_ready, 0);
        chk("frame_err_holds", frame_err, exp_err);
        // s_valid in IDLE must not write
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        chk("idle_valid_ignored", bus.wr_en, 0);
        chk("idle_stays_idle", busy, 0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        repeat (2) tick();
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick();

        bus.s_valid = 1'b1;
        bus.s_data  = 24'h123456;
        tick();
        bus.s_valid = 1'b0;
        chk("pre_idle_valid_ignored", bus.wr_en, 0);

        // nominal, stalls, address wrap
        frame(17'h00010, 8, 7, 1'b0, 24'h000001, 24'h000001, -1, 1'b0);
        frame(17'h00010, 8, 7, 1'b1, 24'h000001, 24'h000001, -1, 1'b0);
        frame(17'h1FFFE, 8, 7, 1'b0, 24'hA00000, 24'h000010, -1, 1'b0);
        // early s_last, then final pixel without s_last
        frame(17'h00100, 5, 4, 1'b0, 24'h0A0A0A, 24'h000001, -1, 1'b1);
        frame(17'h00200, 8, -1, 1'b0, 24'h00F000, 24'h000100, -1, 1'b1);
        // start mid-frame ignored
        frame(17'h00040, 8, 7, 1'b0, 24'h550000, 24'h000003, 3, 1'b0);

        // reset mid-frame with a write in flight
        start     = 1'b1;
        base_addr = 17'h00060;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 24'h000111 * 24'(i + 1);
            tick();
        end
        bus.s_valid = 1'b0;
        chk("inflight_wr_en", bus.wr_en, 1);
        chk("inflight_wr_addr", bus.wr_addr, 17'h00062);
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", bus.wr_en, 0);
        chk("async_rst_wr_addr", bus.wr_addr, 0);
        chk("async_rst_wr_data", bus.wr_data, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", bus.s_ready, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_err", frame_err, 0);
        tick();
        chk("no_done_in_reset", done, 0);
        rst_n = 1'b1;
        tick();
        chk("no_done_after_reset", done, 0);
        chk("idle_after_reset", busy, 0);
        frame(17'h00030, 8, 7, 1'b0, 24'h000101, 24'h000101, -1, 1'b0);

`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
        frame(17'h00000, 8, 7, 1'b0, 24'hFFFFFF, 24'h000000, -1, 1'b0);
        chk("checksum_all_ones", checksum, 32'h07FFFFF8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
